// File: rtl/cpu_run_ctrl.sv
// Host-driven RUN/STEP/STOP/CLEAR sequencer gating the core enable, with ecall halt,
// optional RUN watchdog and a saturating retired counter; all outputs registered, commands always accepted.
module cpu_run_ctrl #(
   parameter int CNT_W      = 32,
   parameter int STEP_W     = 16,
   parameter int MAX_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [STEP_W-1:0] cmd_arg,
   input  logic              ecall,
   output logic              core_run,
   output logic              busy,
   output logic              halted,
   output logic              timeout,
   output logic              done,
   output logic              cmd_err,
   output logic [CNT_W-1:0]  retired
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALT} state_t;

   localparam logic [1:0]  OP_RUN   = 2'd0;
   localparam logic [1:0]  OP_STEP  = 2'd1;
   localparam logic [1:0]  OP_STOP  = 2'd2;
   localparam logic [1:0]  OP_CLEAR = 2'd3;
   localparam logic [31:0] WD_LAST  = 32'(MAX_CYCLES - 1);
   localparam bit          WD_EN    = (MAX_CYCLES != 0);

   state_t            state_q, state_d;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
   logic [31:0]       wd_q, wd_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              cmd_ready_q;
   logic              core_run_q, core_run_d;
   logic              busy_q, busy_d;
   logic              halted_q, halted_d;
   logic              timeout_q, timeout_d;
   logic              done_q, done_d;
   logic              cmd_err_q, cmd_err_d;
   logic              acc, is_run, is_step, is_stop, is_clear, ecall_hit, wd_hit;

   always_comb begin
      acc       = cmd_valid & cmd_ready_q;
      is_run    = acc & (cmd_op == OP_RUN);
      is_step   = acc & (cmd_op == OP_STEP);
      is_stop   = acc & (cmd_op == OP_STOP);
      is_clear  = acc & (cmd_op == OP_CLEAR);
      ecall_hit = ecall & core_run_q;
      // wd_q counts completed RUN cycles, so hitting WD_LAST marks the MAX_CYCLES-th one
      wd_hit    = WD_EN && (state_q == S_RUN) && (wd_q == WD_LAST);

      state_d    = state_q;
      step_cnt_d = step_cnt_q;
      wd_d       = wd_q;
      retired_d  = retired_q;
      timeout_d  = timeout_q;
      done_d     = 1'b0;
      cmd_err_d  = 1'b0;

      if (core_run_q && (retired_q != '1))
         retired_d = retired_q + CNT_W'(1);

      case (state_q)
         S_IDLE: begin
            if (is_run) begin
               state_d = S_RUN;
               wd_d    = '0;
            end else if (is_step) begin
               if (cmd_arg != '0) begin
                  state_d    = S_STEP;
                  step_cnt_d = cmd_arg;
               end else begin
                  done_d = 1'b1;
               end
            end else if (is_clear) begin
               retired_d = '0;
            end
         end
         S_RUN: begin
            cmd_err_d = acc & ~is_stop;
            wd_d      = wd_q + 32'd1;
            if (ecall_hit) begin
               state_d = S_HALT;
               done_d  = 1'b1;
            end else if (wd_hit) begin
               state_d   = S_HALT;
               timeout_d = 1'b1;
               done_d    = 1'b1;
            end else if (is_stop) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         S_STEP: begin
            cmd_err_d  = acc & ~is_stop;
            step_cnt_d = step_cnt_q - STEP_W'(1);
            if (ecall_hit) begin
               state_d = S_HALT;
               done_d  = 1'b1;
            end else if (is_stop || (step_cnt_q == STEP_W'(1))) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         S_HALT: begin
            cmd_err_d = is_run | is_step;
            if (is_clear) begin
               state_d   = S_IDLE;
               timeout_d = 1'b0;
               retired_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      core_run_d = (state_d == S_RUN) || (state_d == S_STEP);
      busy_d     = core_run_d;
      halted_d   = (state_d == S_HALT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         step_cnt_q  <= '0;
         wd_q        <= '0;
         retired_q   <= '0;
         cmd_ready_q <= 1'b0;
         core_run_q  <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
         timeout_q   <= 1'b0;
         done_q      <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_cnt_q  <= step_cnt_d;
         wd_q        <= wd_d;
         retired_q   <= retired_d;
         cmd_ready_q <= 1'b1;
         core_run_q  <= core_run_d;
         busy_q      <= busy_d;
         halted_q    <= halted_d;
         timeout_q   <= timeout_d;
         done_q      <= done_d;
         cmd_err_q   <= cmd_err_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign core_run  = core_run_q;
   assign busy      = busy_q;
   assign halted    = halted_q;
   assign timeout   = timeout_q;
   assign done      = done_q;
   assign cmd_err   = cmd_err_q;
   assign retired   = retired_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios with literal expectations, then random
// commands/ecalls/resets compared every cycle against a behavioural model.
module tb_cpu_run_ctrl;
   localparam int CNT_W   = 6;
   localparam int STEP_W  = 8;
   localparam int MAXC    = 8;
   localparam int RET_MAX = (1 << CNT_W) - 1;
   localparam logic [1:0] RUN = 2'd0, STEP = 2'd1, STOP = 2'd2, CLEAR = 2'd3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [1:0]        cmd_op = 2'd0;
   logic [STEP_W-1:0] cmd_arg = '0;
   logic              ecall = 1'b0;
   logic              core_run, busy, halted, timeout, done, cmd_err;
   logic [CNT_W-1:0]  retired;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   // behavioural model
   bit m_running = 0, m_halted = 0, m_timeout = 0, m_done = 0, m_err = 0, m_rdy = 0;
   int m_retired = 0;
   int m_left = 0;   // steps remaining; 0 while in an unbounded RUN
   int m_wd = 0;     // core_run cycles since RUN accepted

   cpu_run_ctrl #(.CNT_W(CNT_W), .STEP_W(STEP_W), .MAX_CYCLES(MAXC)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ecall(ecall), .core_run(core_run),
      .busy(busy), .halted(halted), .timeout(timeout), .done(done),
      .cmd_err(cmd_err), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin : model
      bit acc;
      acc    = cmd_valid && m_rdy;
      m_done = 0;
      m_err  = 0;
      if (!rst_n) begin
         m_running = 0; m_halted = 0; m_timeout = 0;
         m_retired = 0; m_left = 0; m_wd = 0; m_rdy = 0;
      end else begin
         m_rdy = 1;
         if (m_running) begin
            m_retired = (m_retired == RET_MAX) ? RET_MAX : m_retired + 1;
            m_wd++;
            if (acc && cmd_op != STOP) m_err = 1;
            if (ecall) begin
               m_running = 0; m_halted = 1; m_done = 1;
            end else if (m_left == 0 && m_wd == MAXC) begin
               m_running = 0; m_halted = 1; m_timeout = 1; m_done = 1;
            end else if (acc && cmd_op == STOP) begin
               m_running = 0; m_done = 1;
            end else if (m_left == 1) begin
               m_running = 0; m_done = 1;
            end else if (m_left > 1) begin
               m_left--;
            end
         end else if (m_halted) begin
            if (acc && (cmd_op == RUN || cmd_op == STEP)) m_err = 1;
            if (acc && cmd_op == CLEAR) begin
               m_halted = 0; m_timeout = 0; m_retired = 0;
            end
         end else if (acc) begin
            case (cmd_op)
               RUN:  begin m_running = 1; m_left = 0; m_wd = 0; end
               STEP: begin
                  if (cmd_arg != 0) begin m_running = 1; m_left = int'(cmd_arg); end
                  else m_done = 1;
               end
               CLEAR: m_retired = 0;
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("core_run", core_run, m_running);
         chk("busy", busy, m_running);
         chk("halted", halted, m_halted);
         chk("timeout", timeout, m_timeout);
         chk("done", done, m_done);
         chk("cmd_err", cmd_err, m_err);
         chk("cmd_ready", cmd_ready, m_rdy);
         chk("retired", retired, m_retired);
      end
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [1:0] op, input int arg);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = STEP_W'(arg);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      wait_n(3);
      chk_en = 1'b1;
      chk("rst core_run", core_run, 0);
      chk("rst cmd_ready", cmd_ready, 0);
      chk("rst retired", retired, 0);
      chk("rst halted", halted, 0);
      chk("rst done", done, 0);
      rst_n = 1'b1;
      wait_n(1);
      chk("ready after rst", cmd_ready, 1);

      // ecall while idle has no effect
      ecall = 1'b1;
      wait_n(1);
      ecall = 1'b0;
      chk("idle ecall halted", halted, 0);

      // STEP 3
      send(STEP, 3);
      chk("step3 running", core_run, 1);
      wait_n(2);
      chk("step3 last cycle", core_run, 1);
      wait_n(1);
      chk("step3 done", done, 1);
      chk("step3 idle", core_run, 0);
      chk("step3 retired", retired, 3);
      chk("model step3 retired", m_retired, 3);
      send(CLEAR, 0);
      chk("idle clear", retired, 0);

      // RUN, ecall on 5th cycle
      send(RUN, 0);
      wait_n(4);
      ecall = 1'b1;
      wait_n(1);
      ecall = 1'b0;
      chk("ecall halted", halted, 1);
      chk("ecall retired", retired, 5);
      chk("ecall done", done, 1);
      send(RUN, 0);
      chk("halt run err", cmd_err, 1);
      chk("halt stays", halted, 1);
      send(CLEAR, 0);
      chk("clear halted", halted, 0);
      chk("clear retired", retired, 0);

      // watchdog
      send(RUN, 0);
      wait_n(7);
      chk("wd 8th cycle", core_run, 1);
      wait_n(1);
      chk("wd halted", halted, 1);
      chk("wd timeout", timeout, 1);
      chk("wd retired", retired, 8);
      chk("model wd retired", m_retired, 8);
      wait_n(2);
      chk("timeout sticky", timeout, 1);
      send(CLEAR, 0);
      chk("clear timeout", timeout, 0);

      // STEP 2 with ecall on final step, then STEP 0
      send(STEP, 2);
      wait_n(1);
      ecall = 1'b1;
      wait_n(1);
      ecall = 1'b0;
      chk("step ecall halted", halted, 1);
      chk("step ecall done", done, 1);
      chk("step ecall retired", retired, 2);
      wait_n(1);
      chk("done once", done, 0);
      send(CLEAR, 0);
      send(STEP, 0);
      chk("step0 done", done, 1);
      chk("step0 no run", core_run, 0);

      // RUN then STOP on 4th cycle
      send(RUN, 0);
      wait_n(3);
      send(STOP, 0);
      chk("stop retired", retired, 4);
      chk("stop done", done, 1);
      chk("stop idle", busy, 0);

      // reset mid-RUN
      send(RUN, 0);
      wait_n(2);
      rst_n = 1'b0;
      wait_n(1);
      chk("midrst core_run", core_run, 0);
      chk("midrst done", done, 0);
      chk("midrst retired", retired, 0);
      chk("midrst ready", cmd_ready, 0);
      rst_n = 1'b1;
      wait_n(1);

      // saturation
      send(STEP, 70);
      wait_n(70);
      chk("sat done", done, 1);
      chk("sat retired", retired, RET_MAX);

      // random phase
      for (int i = 0; i < 4000; i++) begin
         rst_n     = ($urandom_range(0, 299) != 0);
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_op    = 2'($urandom_range(0, 3));
         cmd_arg   = STEP_W'($urandom_range(0, 6));
         ecall     = ($urandom_range(0, 9) == 0);
         wait_n(1);
      end
      cmd_valid = 1'b0;
      ecall     = 1'b0;
      rst_n     = 1'b1;
      wait_n(2);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 Parameter STEP_W, default 16: width of the step-count argument.
REQ-003 Parameter MAX_CYCLES, default 0: RUN-mode watchdog limit in cycles; 0 disables the watchdog.
REQ-004 clk  input  1  Single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  Reset, synchronous and active-low.
REQ-006 cmd_valid  input  1  Host command request.
REQ-007 cmd_ready  output  1  Command accept; a command is taken when cmd_valid and cmd_ready are both 1.
REQ-008 cmd_op  input  2  Command opcode: 0=RUN, 1=STEP, 2=STOP, 3=CLEAR.
REQ-009 cmd_arg  input  STEP_W  Instruction count for STEP; ignored for other ops.
REQ-010 ecall  input  1  Core ecall strobe for the instruction executing this cycle.
REQ-011 core_run  output  1  Core enable; one instruction retires per cycle while high.
REQ-012 busy  output  1  High in RUN or STEP.
REQ-013 halted  output  1  High in HALT.
REQ-014 timeout  output  1  Sticky; set when the watchdog caused HALT.
REQ-015 done  output  1  One-cycle pulse at the end of any run, step or stop sequence.
REQ-016 cmd_err  output  1  One-cycle pulse when an accepted command is illegal in the current state.
REQ-017 retired  output  CNT_W  Count of core_run-high cycles.

Function
REQ-018 States SHALL be IDLE, RUN, STEP and HALT; core_run SHALL decode from the registered state (1 in RUN and STEP only), with no combinational path from any input.
REQ-019 cmd_ready SHALL be constant 1 out of reset; every command is accepted and is either executed or flagged with cmd_err.
REQ-020 IDLE: RUN -> RUN, clear the watchdog counter; STEP with arg>0 -> STEP, load step_cnt=arg; STEP with arg=0 -> stay in IDLE with a done pulse; STOP -> no-op; CLEAR -> retired=0.
REQ-021 RUN: ecall -> HALT with done; watchdog counter reaching MAX_CYCLES (MAX_CYCLES!=0) -> HALT with timeout=1 and done; STOP -> IDLE with done; RUN, STEP or CLEAR -> cmd_err, state unchanged.
REQ-022 STEP: step_cnt decrements each cycle; the cycle with step_cnt==1 -> IDLE with done; ecall -> HALT with done; STOP -> IDLE with done; RUN, STEP or CLEAR -> cmd_err.
REQ-023 HALT: CLEAR -> IDLE, clears halted, timeout and retired; RUN or STEP -> cmd_err; STOP -> no-op.
REQ-024 Same-cycle priority SHALL be ecall > watchdog > STOP > step expiry; an ecall on the final step goes to HALT.
REQ-025 ecall SHALL be ignored when core_run=0.
REQ-026 After RUN is accepted, exactly MAX_CYCLES core_run cycles SHALL occur before a watchdog HALT; STEP is not watchdog-limited.
REQ-027 retired SHALL increment in every core_run=1 cycle, including the terminating cycle, and saturate at all-ones.
REQ-028 done and cmd_err SHALL be registered and assert in the cycle the new state first takes effect, high for exactly 1 cycle.
REQ-029 timeout SHALL remain set until CLEAR or reset.

Reset
REQ-030 While rst_n=0 at posedge clk: state=IDLE; core_run, busy, halted, timeout, done, cmd_err=0; retired, step_cnt and watchdog=0; cmd_ready=0.
REQ-031 A reset during RUN or STEP SHALL drop core_run at that same edge, with no done pulse; commands during reset SHALL be ignored.

Verification
REQ-032 IDLE, STEP arg=3 -> core_run high for exactly 3 cycles, retired=3, done one cycle after the last, back in IDLE.
REQ-033 RUN, ecall on the 5th run cycle -> HALT, halted=1, retired=5, done pulse; a following RUN -> cmd_err; CLEAR -> IDLE, retired=0.
REQ-034 MAX_CYCLES=8, RUN, no ecall -> 8 core_run cycles, HALT, timeout=1, retired=8.
REQ-035 STEP arg=2 with ecall on the 2nd cycle -> HALT (not IDLE), done once; STEP arg=0 -> done pulse, core_run never high.
REQ-036 RUN then STOP on the 4th cycle -> IDLE, retired=4, done; rst_n=0 mid-RUN -> core_run=0 at that edge, all outputs at their reset values, no done.
